// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding, instruction size and default vectors for pc_sequencer
package pc_seq_pkg;
   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALTED} state_t;
   localparam logic [31:0] INSN_BYTES = 32'd4;
   localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEF_TRAP_VECTOR = 32'h0000_0080;
   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next fetch address select (jump > branch > sequential), targets word aligned
// Ports: pc (current instruction address), jump/jump_target, branch_taken/branch_target,
//        next_pc (aligned next fetch address; sequential case wraps modulo 2^32)
module pc_next_sel
   import pc_seq_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] next_pc
);
   assign next_pc = jump ? align(jump_target) : branch_taken ? align(branch_target) : pc + INSN_BYTES;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction fetch sequencer (fetch -> issue handshake -> redirect/halt)
// Ports: clk, rst_n (sync, active-low); imem_req/imem_addr/imem_ack/imem_rdata fetch port;
//        inst/pc/inst_valid/inst_ready downstream handshake; jump/branch_taken + targets and
//        halt sampled on the issue handshake only.
// Optional: PC_TRAP_EN adds TRAP_VECTOR, trap input and epc output.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
`ifdef PC_TRAP_EN
   , parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR
`endif
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid,
   input  logic        inst_ready,
   input  logic        jump,
   input  logic        branch_taken,
   input  logic [31:0] jump_target,
   input  logic [31:0] branch_target,
   input  logic        halt
`ifdef PC_TRAP_EN
   , input  logic        trap
   , output logic [31:0] epc
`endif
);
   state_t state, state_nxt;
   logic [31:0] fetch_pc, next_pc;
   logic trap_take, ack_take, hs;
   pc_next_sel u_sel (
      .pc(pc),
      .jump(jump),
      .jump_target(jump_target),
      .branch_taken(branch_taken),
      .branch_target(branch_target),
      .next_pc(next_pc)
   );
`ifdef PC_TRAP_EN
   assign trap_take = trap && (state == FETCH || state == ISSUE);
`else
   assign trap_take = 1'b0;
`endif
   // a trap aborts both a pending fetch and an offered instruction
   assign ack_take = state == FETCH && imem_ack && !trap_take;
   assign hs = state == ISSUE && inst_ready && !trap_take;
   assign imem_addr = fetch_pc;
   always_comb begin
      imem_req = state == FETCH;
      inst_valid = state == ISSUE;
      state_nxt = trap_take ? FETCH :
                  state == IDLE ? FETCH :
                  ack_take ? ISSUE :
                  hs ? (halt ? HALTED : FETCH) : state;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc <= RESET_VECTOR;
         pc <= RESET_VECTOR;
         inst <= '0;
      end else begin
         if (ack_take) begin
            inst <= imem_rdata;
            pc <= fetch_pc;
         end
         if (hs) fetch_pc <= next_pc;
`ifdef PC_TRAP_EN
         if (trap_take) fetch_pc <= TRAP_VECTOR;
`endif
      end
   end
`ifdef PC_TRAP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) epc <= '0;
      else if (trap_take) epc <= pc;
   end
`endif
endmodule
